adc_frame_align: RTL and testbench
==================================

# adc_frame_align

Frame-lane bit alignment controller for the ADC LVDS capture path. It sits directly downstream of the reset sequencer and starts work when `rst_pro` is released. It watches the parallel word from the frame-clock lane ISERDES and issues `bitslip` pulses until that word equals the expected frame pattern. It then declares lock and keeps monitoring, retraining if lock is lost. Data-lane capture logic uses `frame_locked` as its valid qualifier.

## Interface
- `FRAME_PATTERN`, default 8'hF0: expected deserialised frame word.
- `SETTLE_CYC`, default 4: cycles ignored after each bitslip (ISERDES output latency).
- `LOCK_CNT`, default 16: consecutive matching words needed to declare lock.
- `MAX_SLIPS`, default 8: bitslips allowed per attempt before failure.
- `LOSS_CNT`, default 4: consecutive mismatches while locked that drop lock.

- `clk`  in  1: ISERDES divided clock; the only clock in the block.
- `rst_pro`  in  1: synchronous, active-high reset (driven by the reset sequencer).
- `align_start`  in  1: single-cycle retrain request.
- `frame_data`  in  8: ISERDES parallel output for the frame lane.
- `bitslip`  out  1: single-cycle pulse to ISERDES BITSLIP.
- `frame_locked`  out  1: frame alignment achieved and held.
- `align_err`  out  1: MAX_SLIPS exhausted without lock; sticky until restart.
- `slip_count`  out  4: bitslips issued in the current attempt, range 0..MAX_SLIPS.

## Operation
- **States:** IDLE, CHECK, SLIP, SETTLE, LOCKED, FAIL.
- **Reset:** while `rst_pro`=1, the block is in IDLE and all outputs are 0. The match, loss, settle and slip counters are all 0.
- **IDLE:** moves to CHECK unconditionally on the next edge (auto-start).
- **CHECK:**
  - A matching word (`frame_data==FRAME_PATTERN`) increments the match counter.
  - When the counter reaches LOCK_CNT, the block enters LOCKED.
  - A mismatch clears the match counter. If slips < MAX_SLIPS, the block goes to SLIP; otherwise it goes to FAIL.
- **SLIP:** drives `bitslip`=1 for exactly one cycle, increments slip_count, then goes to SETTLE.
- **SETTLE:** counts SETTLE_CYC cycles with `frame_data` ignored, then returns to CHECK with the match counter at 0.
- **LOCKED:**
  - `frame_locked`=1.
  - Each mismatch increments the loss counter; any match clears it.
  - When the loss counter reaches LOSS_CNT, `frame_locked` drops and the block goes to CHECK with slip_count and all counters cleared.
- **FAIL:** `align_err`=1 and `frame_locked`=0. The block stays in FAIL until `align_start` or reset.
- **align_start:**
  - Accepted in any state.
  - Next state is CHECK; all counters are cleared; `align_err` and `frame_locked` go to 0.
  - Any `bitslip` pulse due that cycle is suppressed.
- **Priority:** `rst_pro` > `align_start` > normal transitions.
- **Counter widths:** counters saturate and never wrap. The match counter is sized by $clog2(LOCK_CNT+1).
- **Output:** slip_count holds its value while in LOCKED and FAIL.
- **Illegal state encodings** recover to IDLE.

## Timing
- All outputs are registered. `bitslip` is high in the cycle after the decision edge and never high on two consecutive cycles.
- **Lock latency, clean pattern:** edge 1 after `rst_pro` falls moves IDLE→CHECK. `frame_locked` rises at edge 1+LOCK_CNT (edge 17 with defaults).
- **Per-slip cost:** 1 (mismatch detect) + 1 (SLIP) + SETTLE_CYC cycles before sampling resumes.
- **Worst-case failure:** `align_err` asserts after MAX_SLIPS×(SETTLE_CYC+2)+1 cycles of continuous mismatch from CHECK entry.
- **Loss of lock:** `frame_locked` falls on the LOSS_CNT-th consecutive mismatch edge.
- **Reset mid-operation:** a `bitslip` pulse in flight is cut short on the reset edge. No partial state survives.

## Structure
- **Package `adc_align_pkg`:** state enum typedef, default FRAME_PATTERN constant, and the slip_count width localparam (shared with the data-lane capture logic).
- **Sub-modules:** none; a single FSM-plus-counters module is natural.
- **Implementation size:** roughly 150–200 lines.

## Test plan
- **Clean pattern:** reset for 5 cycles, then `frame_data`=8'hF0 constant → `frame_locked`=1 at edge 17, `bitslip` never pulses, `slip_count`=0.
- **Rotated pattern:** a model rotates the word by 1 bit per `bitslip`, starting at 8'h1E (three slips from 8'hF0) → exactly 3 `bitslip` pulses, each followed by ≥4 quiet cycles. `slip_count`=3, then `frame_locked`=1.
- **Never matches:** `frame_data`=8'h00 forever → 8 pulses, then `align_err`=1 at cycle 8×6+1 after CHECK entry, `frame_locked`=0. `align_err` stays sticky for 100 cycles.
- **Loss of lock:** while locked, inject 3 mismatches, 1 match, then 4 mismatches → lock holds through the 3 mismatches and drops on the 4th consecutive one. Realignment then restarts with `slip_count`=0.
- **Restart and reset:** from FAIL, pulse `align_start` → `align_err`=0 next cycle and realignment proceeds. Separately, assert `rst_pro` during SETTLE → all outputs 0 next edge, then a clean restart.

Source files
------------

// File: rtl/adc_align_pkg.sv
// Shared types and constants for the ADC frame-lane alignment controller.
// The slip counter width is also used by the data-lane capture logic.
package adc_align_pkg;

    localparam int unsigned SLIP_CNT_W            = 4;
    localparam logic [7:0]  DEFAULT_FRAME_PATTERN = 8'hF0;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StCheck  = 3'd1,
        StSlip   = 3'd2,
        StSettle = 3'd3,
        StLocked = 3'd4,
        StFail   = 3'd5
    } align_state_e;

endpackage

// File: rtl/adc_frame_align.sv
// Frame-lane bit alignment: issues ISERDES bitslips until the frame word matches,
// then holds lock and retrains on sustained mismatch.
module adc_frame_align
    import adc_align_pkg::*;
#(
    parameter logic [7:0]  FRAME_PATTERN = DEFAULT_FRAME_PATTERN,
    parameter int unsigned SETTLE_CYC    = 4,
    parameter int unsigned LOCK_CNT      = 16,
    parameter int unsigned MAX_SLIPS     = 8,
    parameter int unsigned LOSS_CNT      = 4
) (
    input  logic                  clk,
    input  logic                  rst_pro,
    input  logic                  align_start,
    input  logic [7:0]            frame_data,
    output logic                  bitslip,
    output logic                  frame_locked,
    output logic                  align_err,
    output logic [SLIP_CNT_W-1:0] slip_count
);

    localparam int unsigned MATCH_W  = $clog2(LOCK_CNT + 1);
    localparam int unsigned LOSS_W   = $clog2(LOSS_CNT + 1);
    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYC + 1);

    align_state_e          r_state, w_state_d;
    logic [MATCH_W-1:0]    r_match, w_match_d;
    logic [LOSS_W-1:0]     r_loss, w_loss_d;
    logic [SETTLE_W-1:0]   r_settle, w_settle_d;
    logic [SLIP_CNT_W-1:0] r_slip, w_slip_d;
    logic                  r_bitslip, w_bitslip_d;
    logic                  r_locked, w_locked_d;
    logic                  r_err, w_err_d;
    logic                  w_match;

    assign w_match = (frame_data == FRAME_PATTERN);

    always_comb begin
        w_state_d   = r_state;
        w_match_d   = r_match;
        w_loss_d    = r_loss;
        w_settle_d  = r_settle;
        w_slip_d    = r_slip;
        w_bitslip_d = 1'b0;
        w_locked_d  = r_locked;
        w_err_d     = r_err;

        if (align_start) begin
            // Retrain wins over any transition, including a bitslip due this cycle.
            w_state_d  = StCheck;
            w_match_d  = '0;
            w_loss_d   = '0;
            w_settle_d = '0;
            w_slip_d   = '0;
            w_locked_d = 1'b0;
            w_err_d    = 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    w_state_d = StCheck;
                end
                StCheck: begin
                    if (w_match) begin
                        if (32'(r_match) < LOCK_CNT) begin
                            w_match_d = r_match + MATCH_W'(1);
                        end
                        if ((32'(r_match) + 32'd1) >= LOCK_CNT) begin
                            w_state_d  = StLocked;
                            w_locked_d = 1'b1;
                            w_loss_d   = '0;
                        end
                    end else begin
                        w_match_d = '0;
                        if (32'(r_slip) < MAX_SLIPS) begin
                            w_state_d   = StSlip;
                            w_bitslip_d = 1'b1;
                            w_slip_d    = r_slip + SLIP_CNT_W'(1);
                        end else begin
                            w_state_d  = StFail;
                            w_err_d    = 1'b1;
                            w_locked_d = 1'b0;
                        end
                    end
                end
                StSlip: begin
                    w_state_d  = StSettle;
                    w_settle_d = '0;
                end
                StSettle: begin
                    // frame_data is stale here while the ISERDES pipeline refills.
                    if ((32'(r_settle) + 32'd1) >= SETTLE_CYC) begin
                        w_state_d  = StCheck;
                        w_settle_d = '0;
                        w_match_d  = '0;
                    end else begin
                        w_settle_d = r_settle + SETTLE_W'(1);
                    end
                end
                StLocked: begin
                    if (w_match) begin
                        w_loss_d = '0;
                    end else if ((32'(r_loss) + 32'd1) >= LOSS_CNT) begin
                        w_state_d  = StCheck;
                        w_locked_d = 1'b0;
                        w_loss_d   = '0;
                        w_match_d  = '0;
                        w_settle_d = '0;
                        w_slip_d   = '0;
                    end else begin
                        w_loss_d = r_loss + LOSS_W'(1);
                    end
                end
                StFail: begin
                    w_err_d    = 1'b1;
                    w_locked_d = 1'b0;
                end
                default: begin
                    w_state_d  = StIdle;
                    w_match_d  = '0;
                    w_loss_d   = '0;
                    w_settle_d = '0;
                    w_slip_d   = '0;
                    w_locked_d = 1'b0;
                    w_err_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_pro) begin
            r_state   <= StIdle;
            r_match   <= '0;
            r_loss    <= '0;
            r_settle  <= '0;
            r_slip    <= '0;
            r_bitslip <= 1'b0;
            r_locked  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_match   <= w_match_d;
            r_loss    <= w_loss_d;
            r_settle  <= w_settle_d;
            r_slip    <= w_slip_d;
            r_bitslip <= w_bitslip_d;
            r_locked  <= w_locked_d;
            r_err     <= w_err_d;
        end
    end

    assign bitslip      = r_bitslip;
    assign frame_locked = r_locked;
    assign align_err    = r_err;
    assign slip_count   = r_slip;

endmodule

// File: tb/tb_adc_frame_align.sv
// Directed bench for adc_frame_align with a small ISERDES bitslip rotation model.
module tb_adc_frame_align;

    logic       clk;
    logic       rst_pro;
    logic       align_start;
    logic [7:0] frame_data;
    logic       bitslip;
    logic       frame_locked;
    logic       align_err;
    logic [3:0] slip_count;

    int   n_asserts = 0;
    int   n_fail    = 0;
    int   cyc;
    int   n_pulses;
    int   last_pulse;
    int   min_gap;
    int   lock_edge;
    int   err_edge;
    logic rot_en;
    logic sticky;

    adc_frame_align u_dut (
        .clk          (clk),
        .rst_pro      (rst_pro),
        .align_start  (align_start),
        .frame_data   (frame_data),
        .bitslip      (bitslip),
        .frame_locked (frame_locked),
        .align_err    (align_err),
        .slip_count   (slip_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; the frame word rotates left when the ISERDES sees a bitslip pulse.
    task automatic tick();
        logic w_bs;
        w_bs = bitslip;
        @(posedge clk);
        #1;
        cyc++;
        if (rot_en && w_bs) frame_data = {frame_data[6:0], frame_data[7]};
        if (bitslip) begin
            if (last_pulse >= 0 && (cyc - last_pulse) < min_gap) min_gap = cyc - last_pulse;
            last_pulse = cyc;
            n_pulses++;
        end
    endtask

    task automatic do_reset(input int n);
        rst_pro = 1'b1;
        repeat (n) tick();
        n_pulses   = 0;
        last_pulse = -1;
        min_gap    = 1000;
        cyc        = 0;
        rst_pro    = 1'b0;
    endtask

    initial begin
        rst_pro     = 1'b1;
        align_start = 1'b0;
        frame_data  = 8'hF0;
        rot_en      = 1'b0;
        cyc         = 0;
        n_pulses    = 0;
        last_pulse  = -1;
        min_gap     = 1000;

        // Clean pattern
        repeat (5) tick();
        chk("rst_bitslip", 32'(bitslip), 0);
        chk("rst_locked", 32'(frame_locked), 0);
        chk("rst_err", 32'(align_err), 0);
        chk("rst_slip_count", 32'(slip_count), 0);
        do_reset(0);
        repeat (16) tick();
        chk("clean_not_locked_e16", 32'(frame_locked), 0);
        tick();
        chk("clean_locked_e17", 32'(frame_locked), 1);
        chk("clean_no_pulses", 32'(n_pulses), 0);
        chk("clean_slip_count", 32'(slip_count), 0);

        // Rotated pattern: 8'h1E needs three left rotations to reach 8'hF0
        rst_pro = 1'b1;
        repeat (2) tick();
        frame_data = 8'h1E;
        rot_en     = 1'b1;
        do_reset(0);
        lock_edge = -1;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (frame_locked) begin
                lock_edge = cyc;
                break;
            end
        end
        chk("rot_lock_edge", 32'(lock_edge), 35);
        chk("rot_pulses", 32'(n_pulses), 3);
        chk("rot_min_gap", 32'(min_gap), 6);
        chk("rot_slip_count", 32'(slip_count), 3);
        chk("rot_model_word", 32'(frame_data), 32'hF0);
        rot_en = 1'b0;

        // Never matches
        rst_pro = 1'b1;
        tick();
        frame_data = 8'h00;
        do_reset(1);
        err_edge = -1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (align_err) begin
                err_edge = cyc;
                break;
            end
        end
        chk("fail_err_edge", 32'(err_edge), 50);
        chk("fail_pulses", 32'(n_pulses), 8);
        chk("fail_slip_count", 32'(slip_count), 8);
        chk("fail_locked", 32'(frame_locked), 0);
        sticky = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            sticky = sticky & align_err & ~frame_locked;
        end
        chk("fail_sticky", 32'(sticky), 1);
        chk("fail_no_more_pulses", 32'(n_pulses), 8);
        chk("fail_slip_held", 32'(slip_count), 8);

        // Restart from FAIL
        frame_data  = 8'hF0;
        align_start = 1'b1;
        tick();
        align_start = 1'b0;
        chk("restart_err_clear", 32'(align_err), 0);
        chk("restart_slip_clear", 32'(slip_count), 0);
        repeat (15) tick();
        chk("restart_not_locked", 32'(frame_locked), 0);
        tick();
        chk("restart_locked", 32'(frame_locked), 1);

        // Loss of lock: 3 bad, 1 good, 4 bad
        frame_data = 8'h00;
        repeat (3) tick();
        chk("loss_hold_3", 32'(frame_locked), 1);
        frame_data = 8'hF0;
        tick();
        frame_data = 8'h00;
        repeat (3) tick();
        chk("loss_hold_after_match", 32'(frame_locked), 1);
        tick();
        chk("loss_drop_4th", 32'(frame_locked), 0);
        chk("loss_slip_count_zero", 32'(slip_count), 0);
        tick();
        chk("loss_realign_pulse", 32'(bitslip), 1);
        chk("loss_realign_slip1", 32'(slip_count), 1);

        // Reset during SETTLE
        repeat (2) tick();
        rst_pro = 1'b1;
        tick();
        chk("settle_rst_bitslip", 32'(bitslip), 0);
        chk("settle_rst_locked", 32'(frame_locked), 0);
        chk("settle_rst_err", 32'(align_err), 0);
        chk("settle_rst_slip", 32'(slip_count), 0);
        frame_data = 8'hF0;
        do_reset(1);
        repeat (16) tick();
        chk("rerun_not_locked_e16", 32'(frame_locked), 0);
        tick();
        chk("rerun_locked_e17", 32'(frame_locked), 1);

        // align_start suppresses a bitslip that a mismatch would trigger
        frame_data  = 8'h00;
        align_start = 1'b1;
        tick();
        align_start = 1'b0;
        chk("start_drops_lock", 32'(frame_locked), 0);
        chk("start_no_bitslip", 32'(bitslip), 0);
        tick();
        chk("start_then_slip", 32'(bitslip), 1);
        tick();
        chk("slip_single_cycle", 32'(bitslip), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
